// File: rtl/uart_hex_tx.sv
// Word FIFO feeding an 8N1 UART transmitter that prints each 16-bit word as four
// uppercase ASCII hex characters, optionally followed by CR LF.
module uart_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned APPEND_CRLF  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]      LastChar = (APPEND_CRLF != 0) ? 3'd5 : 3'd3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            push, pop;

    logic [1:0]      state_q, state_d;
    logic [15:0]     word_q, word_d;
    logic [2:0]      char_q, char_d;
    logic [2:0]      bit_q, bit_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic            baud_done;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [7:0]      next_char;

    function automatic logic [7:0] char_byte(input logic [15:0] w, input logic [2:0] idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = w[15:12];
            3'd1:    nib = w[11:8];
            3'd2:    nib = w[7:4];
            default: nib = w[3:0];
        endcase
        if (idx == 3'd4) return 8'h0D;
        if (idx == 3'd5) return 8'h0A;
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign o_ready   = (count_q != FifoFull);
    assign push      = i_valid && o_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign baud_done = (baud_q == BaudLast);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        char_d  = char_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StStart;
                    word_d  = mem_q[rd_ptr_q];
                    char_d  = '0;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_done) begin
                    state_d = StData;
                    bit_d   = '0;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Next character starts with no idle gap inside a word.
                    if (char_q == LastChar) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StStart;
                        char_d  = char_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is registered from next state so o_tx is glitch-free.
    always_comb begin
        next_char = char_byte(word_d, char_d);
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = next_char[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (count_d != '0) || (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            char_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            char_q  <= char_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx at CLKS_PER_BIT=4: a negedge UART monitor decodes the
// line and each step is checked against hand-derived expectations.
module tb_uart_hex_tx;

    localparam int Cpb = 4;

    logic        clk;
    logic        rst;
    logic        valid1, valid2;
    logic [15:0] data1, data2;
    logic        ready1, tx1, busy1;
    logic        ready2, tx2, busy2;

    int checks   = 0;
    int failures = 0;

    uart_hex_tx #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(4), .APPEND_CRLF(1)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (valid1),
        .i_data  (data1),
        .o_ready (ready1),
        .o_tx    (tx1),
        .o_busy  (busy1)
    );

    uart_hex_tx #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(4), .APPEND_CRLF(0)) u_dut_nocrlf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (valid2),
        .i_data  (data2),
        .o_ready (ready2),
        .o_tx    (tx2),
        .o_busy  (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART monitor: samples mid-bit on negedges; gap_q records the high run before each start.
    logic       sel;
    logic       mline;
    logic       mon_act;
    int         mon_cnt;
    logic [7:0] mon_sh;
    int         run;
    int         frame_err;
    logic [7:0] rx_q[$];
    int         gap_q[$];

    assign mline = sel ? tx2 : tx1;

    always @(negedge clk) begin
        run <= mline ? run + 1 : 0;
        if (rst) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (!mline) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
                gap_q.push_back(run);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % Cpb) == 0)
                mon_sh <= {mline, mon_sh[7:1]};
            if (mon_cnt == 38) begin
                if (!mline) frame_err <= frame_err + 1;
                rx_q.push_back(mon_sh);
                mon_act <= 1'b0;
            end
        end
    end

    logic [7:0] exp_q[$];
    int         rx_base;
    int         gap_base;
    int         n;
    int         acc;
    int         hi;
    logic       rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back(hexc(w[15:12]));
        exp_q.push_back(hexc(w[11:8]));
        exp_q.push_back(hexc(w[7:4]));
        exp_q.push_back(hexc(w[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size() - rx_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rx_base + i < rx_q.size()) chk({tag, "_byte"}, rx_q[rx_base + i], exp_q[i]);
            else                           chk({tag, "_missing"}, 32'hFFFF, exp_q[i]);
        end
        exp_q.delete();
        rx_base  = rx_q.size();
        gap_base = gap_q.size();
    endtask

    task automatic wait_idle(input bit which, input int bound, input string tag);
        int k = 0;
        while ((which ? busy2 : busy1) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, which ? busy2 : busy1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; valid1 = 1'b0; data1 = '0; valid2 = 1'b0; data2 = '0; sel = 1'b0;
        run = 0; frame_err = 0; mon_act = 1'b0; mon_cnt = 0; mon_sh = '0;
        rx_base = 0; gap_base = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_ready", ready1, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word 0x1A2F with CRLF
        data1 = 16'h1A2F; valid1 = 1'b1;
        @(negedge clk); valid1 = 1'b0;
        chk("t1_busy_rise", busy1, 1'b1);
        chk("t1_tx_before_pop", tx1, 1'b1);
        @(negedge clk);
        chk("t1_tx_start", tx1, 1'b0);
        n = 2;
        while (n < 2000) begin
            @(negedge clk);
            if (!busy1) break;
            n++;
        end
        chk("t1_busy_len", n, 241);
        exp_q = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
        check_rx("t1_rx");

        // Boundary words back-to-back
        data1 = 16'h0000; valid1 = 1'b1;
        @(negedge clk); data1 = 16'hFFFF;
        @(negedge clk); valid1 = 1'b0;
        wait_idle(1'b0, 1000, "t2_idle");
        chk("t2_gap_in_word", gap_q[gap_base + 1], 4);
        chk("t2_gap_between_words", gap_q[gap_base + 6], 5);
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A,
                  8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
        check_rx("t2_rx");

        // Hold valid with words 1..6: one drains into the FSM, four fill the FIFO
        acc = 0;
        for (int k = 1; k <= 6; k++) begin
            data1 = 16'(acc + 1); valid1 = 1'b1;
            rdy = ready1;
            if (k == 6) chk("t3_ready_6th", rdy, 1'b0);
            if (rdy) acc++;
            if (k < 6) @(negedge clk);
        end
        chk("t3_accepted", acc, 5);
        n = 0;
        while (!ready1 && n < 1000) begin
            @(negedge clk);
            n++;
            valid1 = 1'b0;
        end
        chk("t3_ready_rise", n, 238);
        wait_idle(1'b0, 3000, "t3_idle");
        for (int w = 1; w <= 5; w++) expect_word(16'(w));
        check_rx("t3_rx");

        // Push lands on the same edge as the pop of the queued word
        data1 = 16'h0123; valid1 = 1'b1;
        @(negedge clk); data1 = 16'h4567;
        @(negedge clk); valid1 = 1'b0;
        repeat (240) @(negedge clk);
        data1 = 16'h89AB; valid1 = 1'b1;
        chk("t4_ready_c", ready1, 1'b1);
        @(negedge clk); data1 = 16'hCDEF;
        chk("t4_ready_d", ready1, 1'b1);
        @(negedge clk); data1 = 16'h3C5A;
        chk("t4_ready_e", ready1, 1'b1);
        @(negedge clk); data1 = 16'hA5C3;
        chk("t4_ready_f", ready1, 1'b1);
        @(negedge clk); valid1 = 1'b0;
        chk("t4_full", ready1, 1'b0);
        wait_idle(1'b0, 3000, "t4_idle");
        expect_word(16'h0123); expect_word(16'h4567); expect_word(16'h89AB);
        expect_word(16'hCDEF); expect_word(16'h3C5A); expect_word(16'hA5C3);
        check_rx("t4_rx");

        // Reset during bit 3 of the second character of 0xBEEF
        data1 = 16'hBEEF; valid1 = 1'b1;
        @(negedge clk); data1 = 16'h1111;
        @(negedge clk); data1 = 16'h2222;
        @(negedge clk); valid1 = 1'b0;
        repeat (56) @(negedge clk);
        chk("t5_tx_bit3", tx1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_tx", tx1, 1'b1);
        chk("t5_rst_ready", ready1, 1'b1);
        chk("t5_rst_busy", busy1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx1) hi++;
        end
        chk("t5_line_idle", hi, 100);
        chk("t5_busy_after", busy1, 1'b0);
        exp_q = '{8'h42};
        check_rx("t5_rx");

        // No CRLF variant
        sel = 1'b1;
        repeat (2) @(negedge clk);
        rx_base = rx_q.size();
        data2 = 16'h9C05; valid2 = 1'b1;
        @(negedge clk); valid2 = 1'b0;
        @(negedge clk);
        chk("t6_tx_start", tx2, 1'b0);
        n = 2;
        while (n < 2000) begin
            @(negedge clk);
            if (!busy2) break;
            n++;
        end
        chk("t6_busy_len", n, 161);
        exp_q = '{8'h39, 8'h43, 8'h30, 8'h35};
        check_rx("t6_rx");
        chk("mon_frame_err", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_hex_tx.md
# uart_hex_tx

Transmit-side companion to the board's UART receive path. Accepts 16-bit words on a valid/ready handshake and buffers them in a small FIFO. Each word is sent on the serial line as four uppercase ASCII hex characters, optionally followed by CR LF, using 8N1 framing. It sits between on-board logic (switches, counters, debug taps) and the FTDI `UART_TX` pin, so values can be dumped to a host terminal.

## Interface

- `CLKS_PER_BIT`, 868, clocks per serial bit (868 = 115200 baud at 100 MHz); must be >= 2.
- `FIFO_DEPTH`, 4, word FIFO entries; power of two, >= 2.
- `APPEND_CRLF`, 1, 1 = append 0x0D 0x0A after each word; 0 = hex digits only.

Ports:

- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears FIFO, counters and FSM.
- `i_valid`  in  1  `i_data` is offered this cycle.
- `i_data`  in  16  word to print.
- `o_ready`  out  1  combinational `!full`; a word is accepted on an edge where `i_valid && o_ready`.
- `o_tx`  out  1  serial line; idles high.
- `o_busy`  out  1  registered; high while the FIFO is non-empty or the FSM is not in `IDLE`.

## Operation

- FIFO
  - Push on `i_valid && o_ready`. A push while full is impossible because `o_ready` is low.
  - Pop only when the FSM is in `IDLE` and the FIFO is non-empty. The popped word is latched into the FSM's word register.
  - Push and pop in the same cycle leave the count unchanged.
- Character sequence per word: `i_data[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`, then 0x0D, 0x0A if `APPEND_CRLF`.
- Nibble encoding: 0–9 maps to 0x30–0x39; A–F maps to 0x41–0x46.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: `o_tx`=1. If the FIFO is non-empty, pop, set char index=0, go to `START`.
  - `START`: `o_tx`=0 for `CLKS_PER_BIT` cycles, then go to `DATA` with bit index=0.
  - `DATA`: `o_tx`=char[bit], LSB first, each bit held `CLKS_PER_BIT` cycles. After bit 7, go to `STOP`.
  - `STOP`: `o_tx`=1 for `CLKS_PER_BIT` cycles. Then, if more characters remain in the word, increment char index and go directly to `START` with zero idle gap. Otherwise go to `IDLE`.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It reloads to 0 on every state or bit change and never wraps mid-bit.
- Char index counts 0..3, or 0..5 with CRLF. Bit index counts 0..7.

## Timing

- Reset values (asserted immediately, asynchronously): `o_tx`=1, `o_busy`=0, FIFO empty so `o_ready`=1, FSM=`IDLE`, all counters 0.
- Reset during a frame aborts it. `o_tx` returns high at once. Queued words are discarded and are not resumed.
- Latency for a word accepted at edge E into an empty, idle block:
  - E+1: pop; FSM enters `START`; `o_tx` falls after this edge.
  - `o_busy` rises after edge E.
- Character period is exactly 10×`CLKS_PER_BIT` cycles.
- Word period is 60×`CLKS_PER_BIT` cycles with CRLF, 40×`CLKS_PER_BIT` without. Back-to-back queued words add one `IDLE` cycle between words.
- `o_busy` falls on the edge where the FSM returns to `IDLE` with the FIFO empty.
- `i_data` is sampled only on the accepting edge. Later changes have no effect.

## Test plan

Run the bench at `CLKS_PER_BIT`=4 and decode `o_tx` with a bench UART monitor.

- Reset, then push 0x1A2F once.
  - Monitor receives 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A.
  - `o_tx` low 1 cycle after acceptance.
  - `o_busy` high for 241 cycles, then low.
- Boundary values: push 0x0000 then 0xFFFF back-to-back.
  - Receives "0000\r\nFFFF\r\n".
  - Exactly one idle-high cycle between the first 0x0A stop bit and the next start bit.
- Hold `i_valid`=1 with words 1..6 from an idle state.
  - Exactly 5 words accepted; `o_ready` low from the 6th cycle on.
  - All 5 words are printed in order.
  - `o_ready` rises after the first word's last stop bit.
- Simultaneous push/pop: with the FIFO holding 1 word and the FSM finishing a word, push on the pop cycle.
  - Count stays 1; no word lost or duplicated.
- Reset mid-frame: assert `rst` during bit 3 of the second character of 0xBEEF, with 2 more words queued.
  - `o_tx`=1 immediately; `o_ready`=1; `o_busy`=0.
  - After release, the line stays idle until a new push.
- `APPEND_CRLF`=0: push 0x9C05.
  - Receives 0x39, 0x43, 0x30, 0x35 only.
  - `o_busy` high 161 cycles.
